// File: rtl/ball_motion.sv
// ball_motion: per-frame bouncing-ball position source for the metaballs renderer.
//   On each vsync falling edge (when enabled) every ball centre is stepped by its
//   velocity, one ball per cycle, reflecting off the RADIUS keep-out band, and the
//   finished set is then published atomically.
// Ports:
//   clk_i        pixel clock
//   reset_i      asynchronous active-high reset
//   vsync_i      active-low vsync, synchronous to clk_i
//   enable_i     1 = animate, 0 = freeze
//   pos_x_o      committed x centres, ball i at [10*i +: 10]
//   pos_y_o      committed y centres, ball i at [10*i +: 10]
//   frame_done_o one-cycle pulse when a new set becomes visible
//   busy_o       high while updating or committing
//   frame_cnt_o  committed-frame count, wraps
module ball_motion #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int NUM_BALLS     = 3,
    parameter int RADIUS        = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   vsync_i,
    input  logic                   enable_i,
    output logic [10*NUM_BALLS-1:0] pos_x_o,
    output logic [10*NUM_BALLS-1:0] pos_y_o,
    output logic                   frame_done_o,
    output logic                   busy_o,
    output logic [7:0]             frame_cnt_o
);
    typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

    localparam logic signed [10:0] LO   = 11'(RADIUS);
    localparam logic signed [10:0] HI_X = 11'(SCREEN_WIDTH - 1 - RADIUS);
    localparam logic signed [10:0] HI_Y = 11'(SCREEN_HEIGHT - 1 - RADIUS);
    localparam logic [9:0]         Y0   = 10'(SCREEN_HEIGHT / 2);
    localparam logic [2:0]         LAST = 3'(NUM_BALLS - 1);

    function automatic logic [9:0] init_x(input int i);
        return 10'(220 + 50 * i);
    endfunction

    function automatic logic signed [3:0] init_vx(input int i);
        return 4'((i % 2 == 1) ? -(1 + i % 3) : (1 + i % 3));
    endfunction

    function automatic logic signed [3:0] init_vy(input int i);
        return 4'((i % 2 == 1) ? (1 + (i + 1) % 3) : -(1 + (i + 1) % 3));
    endfunction

    // Returns {new position, new velocity}; a step landing exactly on a bound is kept.
    function automatic logic [13:0] step(input logic [9:0] p, input logic signed [3:0] v,
                                         input logic signed [10:0] hi);
        logic signed [10:0] n;
        n = $signed({1'b0, p}) + $signed({{7{v[3]}}, v});
        return (n < LO) ? {LO[9:0], -v} : (n > hi) ? {hi[9:0], -v} : {n[9:0], v};
    endfunction

    state_t                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic                     vsync_q;
    logic                     start;
    logic                     done_q;
    logic [7:0]               cnt_q;
    logic [9:0]               x_q  [NUM_BALLS];
    logic [9:0]               y_q  [NUM_BALLS];
    logic signed [3:0]        vx_q [NUM_BALLS];
    logic signed [3:0]        vy_q [NUM_BALLS];
    logic [10*NUM_BALLS-1:0]  work_x, work_y;
    logic [10*NUM_BALLS-1:0]  pos_x_q, pos_y_q;

    // Falling edge of vsync starts a frame; ignored unless idle (see FSM).
    assign start = vsync_q & ~vsync_i & enable_i;

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_flat
        assign work_x[10*g +: 10] = x_q[g];
        assign work_y[10*g +: 10] = y_q[g];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = UPDATE;
                idx_d   = '0;
            end
            UPDATE: begin
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q == LAST) ? COMMIT : UPDATE;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                x_q[i]  <= init_x(i);
                y_q[i]  <= Y0;
                vx_q[i] <= init_vx(i);
                vy_q[i] <= init_vy(i);
            end
        end else if (state_q == UPDATE) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (idx_q == 3'(i)) begin
                    {x_q[i], vx_q[i]} <= step(x_q[i], vx_q[i], HI_X);
                    {y_q[i], vy_q[i]} <= step(y_q[i], vy_q[i], HI_Y);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vsync_q <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                pos_x_q[10*i +: 10] <= init_x(i);
                pos_y_q[10*i +: 10] <= Y0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vsync_q <= vsync_i;
            done_q  <= (state_q == COMMIT);
            if (state_q == COMMIT) begin
                pos_x_q <= work_x;
                pos_y_q <= work_y;
                cnt_q   <= cnt_q + 8'd1;
            end
        end
    end

    assign pos_x_o      = pos_x_q;
    assign pos_y_o      = pos_y_q;
    assign frame_done_o = done_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_cnt_o  = cnt_q;
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: scoreboard bench for ball_motion with directed frame sequences.
module tb_ball_motion;
    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        vsync_i = 1'b1;
    logic        enable_i = 1'b1;
    logic [29:0] pos_x_o, pos_y_o;
    logic        frame_done_o, busy_o;
    logic [7:0]  frame_cnt_o;

    ball_motion dut (
        .clk_i(clk), .reset_i(reset_i), .vsync_i(vsync_i), .enable_i(enable_i),
        .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .frame_done_o(frame_done_o),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] px;
        logic [29:0] py;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       q[$];
    int         ntests = 0;
    int         nfail = 0;
    int         mx[3], my[3], mvx[3], mvy[3];
    logic [7:0] mcnt;

    task automatic chk(input string name, input longint act, input longint exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void axis(inout int p, inout int v, input int hi);
        int n;
        n = p + v;
        if (n < 32) begin
            p = 32;
            v = -v;
        end else if (n > hi) begin
            p = hi;
            v = -v;
        end else p = n;
    endfunction

    function automatic logic [29:0] pack(input int a[3]);
        logic [29:0] r;
        for (int i = 0; i < 3; i++) r[10*i +: 10] = a[i][9:0];
        return r;
    endfunction

    task automatic model_reset();
        mx = '{220, 270, 320};
        my = '{240, 240, 240};
        mvx = '{1, -2, 3};
        mvy = '{-2, 3, -1};
        mcnt = 8'd0;
    endtask

    task automatic model_step_push();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            axis(mx[i], mvx[i], 607);
            axis(my[i], mvy[i], 447);
        end
        mcnt = mcnt + 8'd1;
        e.px = pack(mx);
        e.py = pack(my);
        e.cnt = mcnt;
        q.push_back(e);
    endtask

    // Monitor: every frame_done pops one expected set and compares.
    initial forever begin
        @(negedge clk);
        if (frame_done_o) begin
            if (q.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL unexpected_frame_done: got 1 expected 0 (no frame pending)");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_pos_x", pos_x_o, e.px);
                chk("sb_pos_y", pos_y_o, e.py);
                chk("sb_frame_cnt", frame_cnt_o, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_frame(input bit timing);
        int b, lat;
        bit seen;
        model_step_push();
        @(posedge clk); #1 vsync_i = 1'b0;
        b = 0; lat = 0; seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy_o) b++;
            if (frame_done_o) begin
                seen = 1'b1;
                lat = k;
                break;
            end
        end
        chk("frame_done_seen", seen, 1);
        if (timing) begin
            chk("done_latency", lat, 6);
            chk("busy_cycles", b, 4);
        end
        @(posedge clk); #1 vsync_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (frame_done_o) n++;
        end
    endtask

    initial begin
        int n, b;
        model_reset();
        #2 reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pos_x", pos_x_o, {10'd320, 10'd270, 10'd220});
        chk("rst_pos_y", pos_y_o, {10'd240, 10'd240, 10'd240});
        chk("rst_frame_cnt", frame_cnt_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_frame_done", frame_done_o, 0);
        @(posedge clk); #1 reset_i = 1'b0;
        repeat (2) @(posedge clk); #1;

        do_frame(1'b1);
        chk("f1_b0_x", pos_x_o[9:0], 221);
        chk("f1_b0_y", pos_y_o[9:0], 238);
        chk("f1_b1_x", pos_x_o[19:10], 268);
        chk("f1_b1_y", pos_y_o[19:10], 243);
        chk("f1_b2_x", pos_x_o[29:20], 323);
        chk("f1_b2_y", pos_y_o[29:20], 239);
        chk("f1_frame_cnt", frame_cnt_o, 1);

        enable_i = 1'b0;
        b = 0;
        repeat (5) begin
            @(posedge clk); #1 vsync_i = 1'b0;
            repeat (3) begin @(negedge clk); if (busy_o) b++; end
            @(posedge clk); #1 vsync_i = 1'b1;
            repeat (3) begin @(negedge clk); if (busy_o) b++; end
        end
        chk("frozen_busy_cycles", b, 0);
        chk("frozen_pos_x", pos_x_o, pack(mx));
        chk("frozen_pos_y", pos_y_o, pack(my));
        chk("frozen_frame_cnt", frame_cnt_o, mcnt);
        @(posedge clk); #1 enable_i = 1'b1;

        model_step_push();
        @(posedge clk); #1 vsync_i = 1'b0;
        @(posedge clk); #1 vsync_i = 1'b1;
        @(posedge clk); #1 vsync_i = 1'b0;
        count_done(15, n);
        chk("retrigger_done_count", n, 1);
        chk("retrigger_frame_cnt", frame_cnt_o, 3'd2);
        @(posedge clk); #1 vsync_i = 1'b1;
        @(posedge clk); #1;

        model_step_push();
        @(posedge clk); #1 vsync_i = 1'b0;
        @(posedge clk); #1 enable_i = 1'b0;
        count_done(15, n);
        chk("enable_drop_done_count", n, 1);
        chk("enable_drop_frame_cnt", frame_cnt_o, 3);
        @(posedge clk); #1 vsync_i = 1'b1;
        @(posedge clk); #1 enable_i = 1'b1;

        @(posedge clk); #1 vsync_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 reset_i = 1'b1;
        vsync_i = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_pos_x", pos_x_o, {10'd320, 10'd270, 10'd220});
        chk("midrst_pos_y", pos_y_o, {10'd240, 10'd240, 10'd240});
        chk("midrst_frame_cnt", frame_cnt_o, 0);
        chk("midrst_busy", busy_o, 0);
        @(posedge clk); #1 reset_i = 1'b0;
        count_done(12, n);
        chk("midrst_done_count", n, 0);

        for (int f = 1; f <= 400; f++) begin
            do_frame(1'b0);
            if (f == 69 || f == 70) chk("b1_y_at_max", pos_y_o[19:10], 447);
            if (f == 71) chk("b1_y_after_max", pos_y_o[19:10], 444);
            if (f == 104 || f == 105) chk("b0_y_at_min", pos_y_o[9:0], 32);
            if (f == 106) chk("b0_y_after_min", pos_y_o[9:0], 34);
            if (f == 119 || f == 120) chk("b1_x_at_min", pos_x_o[19:10], 32);
            if (f == 121) chk("b1_x_after_min", pos_x_o[19:10], 34);
            if (f == 255) chk("cnt_255", frame_cnt_o, 255);
            if (f == 256) chk("cnt_wrap", frame_cnt_o, 0);
            if (f == 387 || f == 388) chk("b0_x_at_max", pos_x_o[9:0], 607);
            if (f == 389) chk("b0_x_after_max", pos_x_o[9:0], 606);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
